// File: rtl/bios_pkg.sv
// Shared types and constants for the RAM port arbiter.
package bios_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    localparam int unsigned ARB_BIOS_PORT = 0;
    localparam int unsigned ARB_MAX_REQ   = 8;

    // Index of the set bit in a one-hot vector; 0 when the vector is empty.
    function automatic logic [2:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set mask bit at or after the start index, wrapping.
// Requesters that must never win (the BIOS port post-boot) are simply cleared in the mask.
module rr_picker #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0]         i_mask,
    input  logic [$clog2(WIDTH)-1:0] i_start,
    output logic [WIDTH-1:0]         o_pick
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the mask from the start index; the first hit wins.
    always_comb begin
        o_pick = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = IDX_W'((32'(i_start) + i) % WIDTH);
            if (!found && i_mask[idx]) begin
                o_pick[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: BIOS (port 0) owns the RAM before boot, CPU ports share it
// round-robin afterwards. One transaction in flight; requests are latched at grant.
module ram_port_arbiter
    import bios_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned ADDR_WIDTH   = 31,
    parameter int unsigned DATA_WIDTH   = 31,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_booted,
    input  logic [NUM_REQ-1:0]                 i_req,
    input  logic [NUM_REQ-1:0]                 i_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH:0]   i_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH:0]   i_wdata,
    input  logic [NUM_REQ-1:0][3:0]            i_be,
    output logic [NUM_REQ-1:0]                 o_ack,
    output logic [DATA_WIDTH:0]                o_rdata,
    output logic [NUM_REQ-1:0]                 o_grant,
    output logic                               o_ram_read_req,
    output logic [ADDR_WIDTH:0]                o_ram_read_addr,
    input  logic [DATA_WIDTH:0]                i_ram_read_data,
    output logic                               o_ram_write_enable,
    output logic [3:0]                         o_ram_byte_enable,
    output logic [ADDR_WIDTH:0]                o_ram_write_addr,
    output logic [DATA_WIDTH:0]                o_ram_write_data
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 3;

    arb_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH:0]    addr_q, addr_d;
    logic [DATA_WIDTH:0]    wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH:0]    rdata_q, rdata_d;

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     pick;
    logic [IDX_W-1:0]       pick_idx;
    logic                   read_done;

    // Boot level gates the BIOS in and the CPU ports out (and vice versa).
    always_comb begin
        eligible = i_req & {NUM_REQ{i_booted}};
        eligible[ARB_BIOS_PORT] = i_req[ARB_BIOS_PORT] & ~i_booted;
    end

    rr_picker #(
        .WIDTH (NUM_REQ)
    ) u_rr_picker (
        .i_mask  (eligible),
        .i_start (rr_ptr_q),
        .o_pick  (pick)
    );

    assign pick_idx = IDX_W'(onehot_to_idx(ARB_MAX_REQ'(pick)));

    // Counter is loaded with READ_LATENCY-1 and counts down through zero; the ack cycle is
    // the one after it hits zero, i.e. the cycle it has wrapped to all-ones.
    assign read_done = (state_q == ARB_WAIT) && (cnt_q == '1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (|eligible) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = we_q ? ARB_DONE : ARB_WAIT;
            ARB_WAIT:  if (read_done) state_d = ARB_DONE;
            ARB_DONE:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Datapath next-state: latch the winner's request, run the latency counter, rotate pointer.
    always_comb begin
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (|eligible) begin
                    grant_d = pick;
                    owner_d = pick_idx;
                    we_d    = i_we[pick_idx];
                    addr_d  = i_addr[pick_idx];
                    wdata_d = i_wdata[pick_idx];
                    be_d    = i_be[pick_idx];
                end
            end
            ARB_ISSUE: begin
                cnt_d = CNT_W'(READ_LATENCY - 1);
                if (we_q) begin
                    grant_d = '0;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (read_done) begin
                    grant_d = '0;
                    rdata_d = i_ram_read_data;
                end
            end
            ARB_DONE: begin
                grant_d = '0;
                // A BIOS transaction finishing as boot completes also lands the pointer on 1.
                if (i_booted) begin
                    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1)
                                                                 : owner_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= IDX_W'(1);
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs: RAM strobes only in ISSUE; read data bypasses the holding register on its ack.
    always_comb begin
        o_grant            = grant_q;
        o_ack              = '0;
        o_rdata            = rdata_q;
        o_ram_read_req     = 1'b0;
        o_ram_read_addr    = '0;
        o_ram_write_enable = 1'b0;
        o_ram_byte_enable  = '0;
        o_ram_write_addr   = '0;
        o_ram_write_data   = '0;
        case (state_q)
            ARB_ISSUE: begin
                if (we_q) begin
                    o_ram_write_enable = 1'b1;
                    o_ram_byte_enable  = be_q;
                    o_ram_write_addr   = addr_q;
                    o_ram_write_data   = wdata_q;
                    o_ack              = grant_q;
                end else begin
                    o_ram_read_req  = 1'b1;
                    o_ram_read_addr = addr_q;
                end
            end
            ARB_WAIT: begin
                if (read_done) begin
                    o_ack   = grant_q;
                    o_rdata = i_ram_read_data;
                end
            end
            default: ;
        endcase
    end

endmodule
